ram_hidden_reader: RTL
======================

Name: ram_hidden_reader

Overview:
- Read-side sequencer for the hidden-unit RAM: sweeps a contiguous address range and streams each stored word to the downstream consumer (output-layer MAC) over a valid/ready handshake.
- Fully accounts for the RAM's registered read address, where data appears one cycle after the address is sampled.
- Sits between the hidden-unit RAM read port and the output-layer datapath; the RAM write port stays owned by the hidden-layer writer.

Parameters:
- DATA_WIDTH, 8, width of one RAM word / stream beat.
- ADDR_WIDTH, 5, RAM address width; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- start  input  1  begin a sweep; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  first RAM address of the sweep.
- len  input  ADDR_WIDTH+1  number of words to read, 0..2**ADDR_WIDTH.
- ram_addr  output  ADDR_WIDTH  address to the RAM read port (combinational).
- ram_q  input  DATA_WIDTH  RAM read data, equal to ram[addr sampled at previous edge].
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_last  output  1  marks the final beat of the sweep.
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse after the final beat is accepted, or after a len=0 start.

Behaviour:
- State machine: IDLE, STREAM, DONE.
- Registers: ptr (ADDR_WIDTH), remaining (ADDR_WIDTH+1), state.
- Reset (rst_n=0 at posedge): state=IDLE, ptr=0, remaining=0.
  - Outputs after reset: out_valid=0, out_last=0, busy=0, done=0.
  - This applies mid-sweep as well; the in-flight beat is dropped and no done pulse is produced.
- IDLE:
  - ram_addr=start_addr.
  - On start=1 with len>0: ptr<=start_addr, remaining<=len, go to STREAM. The RAM samples start_addr on this same edge.
  - On start=1 with len=0: go to DONE.
- STREAM:
  - out_valid=1; out_data=ram_q (combinational pass-through); out_last=(remaining==1).
  - Handshake fires when out_valid and out_ready are both high.
  - ram_addr = handshake ? ptr+1 : ptr, with modulo 2**ADDR_WIDTH wrap. This gives full throughput: one beat per cycle while out_ready=1, with no bubble.
  - On handshake: ptr<=ptr+1 (wraps), remaining<=remaining-1.
  - If the handshake occurs with out_last=1, go to DONE.
  - With out_ready=0, ram_addr holds at ptr, so ram_q and out_data stay stable. The valid/ready rule holds: valid never drops and data never changes until accepted.
- DONE: done=1, busy=1, out_valid=0, ram_addr=ptr; next state IDLE unconditionally.
- Latency: first beat is valid in the cycle after the start edge.
- start is ignored outside IDLE.
- len=2**ADDR_WIDTH reads every entry once, with wrap from 2**ADDR_WIDTH-1 to 0.
- The block never writes the RAM. Writes to an address not yet read in the current sweep are visible to it; this is the writer's responsibility.

Decomposition:
- Shared package: state enum (IDLE/STREAM/DONE) and the default DATA_WIDTH/ADDR_WIDTH constants used by the RAM, writer and reader.
- No sub-module; the address-mux/pointer logic is small and stays inline.
- The bench instantiates the existing hidden-unit RAM as the read target.

Test Plan:
- RAM preloaded ram[i]=8'h10+i; start, start_addr=0, len=4, out_ready=1 -> beats 10,11,12,13 on consecutive cycles starting one cycle after start; out_last on 13; done pulses the next cycle; busy low after.
- start_addr=30, len=4, out_ready=1 -> beats 2E,2F,10,11 (address wrap 31->0); out_last on 11.
- start_addr=5, len=3, out_ready toggling 1,0,0,1,0,1 -> data 15 then 16 held stable through the stall cycles, then 17 last; no beat duplicated or dropped; 3 handshakes total.
- len=0 with start -> no out_valid; done=1 exactly one cycle after start; state returns to IDLE.
- rst_n=0 asserted for one edge mid-sweep (after 2 of 8 beats) -> out_valid=0, busy=0 on the next cycle, no done pulse; a fresh start with len=2 then streams correctly.
- start pulsed while busy (start_addr=9) -> ignored; the current sweep completes with the original addresses.

Source files
------------

// File: rtl/ram_hidden_reader_pkg.sv
// Shared definitions for the hidden-unit RAM: default geometry and reader states.
// Imported by the RAM, the hidden-layer writer and the reader.
package ram_hidden_reader_pkg;

  localparam int HIDDEN_DATA_WIDTH = 8;
  localparam int HIDDEN_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } reader_state_t;

endpackage

// File: rtl/ram_hidden_reader.sv
// Sweeps a contiguous hidden-RAM address range and streams each word over valid/ready.
// The RAM has a registered read address, so the next address is presented one beat early.
module ram_hidden_reader
  import ram_hidden_reader_pkg::*;
#(
  parameter int DATA_WIDTH = HIDDEN_DATA_WIDTH,
  parameter int ADDR_WIDTH = HIDDEN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  reader_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_remaining;

  reader_state_t         w_state_next;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic [ADDR_WIDTH:0]   w_remaining_next;
  logic [ADDR_WIDTH-1:0] w_ptr_inc;
  logic                  w_handshake;

  assign w_ptr_inc = r_ptr + 1'b1;
  assign out_data  = ram_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_remaining <= w_remaining_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_remaining_next = r_remaining;
    w_handshake      = 1'b0;
    ram_addr         = r_ptr;
    out_valid        = 1'b0;
    out_last         = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // RAM samples start_addr on the start edge so the first beat is ready next cycle.
        ram_addr = start_addr;
        if (start) begin
          if (len != '0) begin
            w_ptr_next       = start_addr;
            w_remaining_next = len;
            w_state_next     = ST_STREAM;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_STREAM: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        out_last    = (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});
        w_handshake = out_ready;
        // Look ahead on acceptance for back-to-back beats; hold otherwise to keep ram_q stable.
        ram_addr    = w_handshake ? w_ptr_inc : r_ptr;
        if (w_handshake) begin
          w_ptr_next       = w_ptr_inc;
          w_remaining_next = r_remaining - 1'b1;
          if (out_last) begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
